// File: rtl/sram_like_pkg.sv
// Shared types and defaults for the SRAM-like responder: size encodings,
// queue entry layout and the write-strobe merge helper.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam int LAT_DEFAULT = 2;
    localparam int QD_DEFAULT  = 4;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic [2:0]  cnt;
    } entry_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// Request/response bus of the SRAM-like responder; the initiator owns the
// request side, the responder owns addr_ok/data_ok/rdata.
interface sram_like_resp_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_resp_queue.sv
// In-order response FIFO of QD entries; every stored entry counts its
// latency down to zero, and the head is ready once its count is zero.
module sram_like_resp_queue
    import sram_like_pkg::*;
#(
    parameter int QD = QD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  entry_t     i_push_entry,
    input  logic       i_pop,
    output entry_t     o_head,
    output logic [3:0] o_count
);

    localparam int PW = $clog2(QD);

    entry_t          r_q [QD];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [3:0]      r_count;

    // Pointers wrap modulo QD, which need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= bump(r_tail);
            if (i_pop)  r_head <= bump(r_head);
            if (i_push && !i_pop)      r_count <= r_count + 4'd1;
            else if (!i_push && i_pop) r_count <= r_count - 4'd1;
        end
    end

    // NOTE: the entry array has no reset; validity is defined solely by head/tail/count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QD; i++) begin
            if (i_push && r_tail == PW'(i)) r_q[i] <= i_push_entry;
            else if (r_q[i].cnt != 3'd0)    r_q[i].cnt <= r_q[i].cnt - 3'd1;
        end
    end

    assign o_head  = r_q[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: word memory with byte strobes, fixed-latency in-order
// responses, up to QD outstanding. Define SRAM_LIKE_RESP_RANDOM_STALL_EN for LFSR backpressure.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = LAT_DEFAULT,
    parameter int QD     = QD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    sram_like_resp_if.slave  bus
);

    logic [31:0]       r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_idx;
    logic              w_room;
    logic              w_addr_ok;
    logic              w_accept;
    logic              w_data_ok;
    entry_t            w_push_entry;
    entry_t            w_head;
    logic [3:0]        w_count;
    logic              w_unused;

    // Upper address bits alias onto the same words; size is informational.
    assign w_idx    = bus.addr[ADDR_W+1:2];
    assign w_unused = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    assign w_room = !reset && (w_count < 4'(QD));

`ifdef SRAM_LIKE_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_addr_ok = w_room && r_lfsr[0];
`else
    assign w_addr_ok = w_room;
`endif

    assign w_accept = bus.req && w_addr_ok;

    // Memory is not reset so committed data survives a reset pulse.
    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) r_mem[w_idx] <= merge_bytes(r_mem[w_idx], bus.wdata, bus.wstrb);
    end

    // NOTE: combinational outputs get a full default first so no latch is inferred.
    always_comb begin
        w_push_entry         = '0;
        w_push_entry.is_read = !bus.wr;
        w_push_entry.data    = bus.wr ? 32'h0 : r_mem[w_idx];
        w_push_entry.cnt     = 3'(LAT - 1);
    end

    sram_like_resp_queue #(
        .QD (QD)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (w_data_ok),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign w_data_ok   = !reset && (w_count != 4'd0) && (w_head.cnt == 3'd0);
    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    assign bus.rdata   = (w_data_ok && w_head.is_read) ? w_head.data : 32'h0;

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp: one LAT=2 instance and one LAT=7 instance
// share the request stimulus; responses are logged and compared in order.
module tb_sram_like_resp;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = SZ_WORD;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] r2_d [$];
    int          r2_c [$];
    logic [31:0] r7_d [$];
    int          r7_c [$];
    int occ2 = 0, occ7 = 0, viol2 = 0, viol7 = 0;

    always #5 clk = ~clk;

    sram_like_resp_if bus2 ();
    sram_like_resp_if bus7 ();

    assign bus2.req = req;   assign bus7.req = req;
    assign bus2.wr = wr;     assign bus7.wr = wr;
    assign bus2.size = size; assign bus7.size = size;
    assign bus2.wstrb = wstrb; assign bus7.wstrb = wstrb;
    assign bus2.addr = addr;   assign bus7.addr = addr;
    assign bus2.wdata = wdata; assign bus7.wdata = wdata;

    sram_like_resp #(.ADDR_W(10), .LAT(2), .QD(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    sram_like_resp #(.ADDR_W(10), .LAT(7), .QD(4)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

    always @(posedge clk) cyc <= cyc + 1;

    // Log responses with their cycle, and track outstanding requests independently.
    always @(negedge clk) begin
        if (reset) begin
            occ2 = 0;
            occ7 = 0;
        end else begin
            if (bus2.data_ok) begin r2_d.push_back(bus2.rdata); r2_c.push_back(cyc); end
            if (bus7.data_ok) begin r7_d.push_back(bus7.rdata); r7_c.push_back(cyc); end
            if (occ2 == 4 && bus2.addr_ok) viol2++;
            if (occ7 == 4 && bus7.addr_ok) viol7++;
            occ2 = occ2 + int'(req && bus2.addr_ok) - int'(bus2.data_ok);
            occ7 = occ7 + int'(req && bus7.addr_ok) - int'(bus7.data_ok);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Present one request and hold it until the selected instance accepts it.
    task automatic issue(input bit sel, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, output int edge_n);
        logic seen;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = SZ_WORD;
        edge_n = -1;
        seen = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (sel ? bus7.addr_ok : bus2.addr_ok) begin
                seen = 1'b1;
                edge_n = cyc + 1;
                break;
            end
            tick();
        end
        check("accept", 32'(seen), 32'd1);
        if (seen) tick();
        req = 1'b0;
    endtask

    // Pop the oldest logged response and compare data and latency from acceptance.
    task automatic expect_resp(input bit sel, input string tag, input logic [31:0] exp_d, input int edge_n);
        logic [31:0] d;
        int          c;
        int          n;
        n = sel ? r7_d.size() : r2_d.size();
        if (n == 0) begin
            check({tag, "_present"}, 32'(n), 32'd1);
            return;
        end
        if (sel) begin d = r7_d.pop_front(); c = r7_c.pop_front(); end
        else     begin d = r2_d.pop_front(); c = r2_c.pop_front(); end
        check({tag, "_data"}, d, exp_d);
        check({tag, "_lat"}, 32'(c - edge_n), sel ? 32'd6 : 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e [5];
        int eg;
        logic [31:0] model [8];
        logic [31:0] exp_d [$];
        int          exp_e [$];

        wait_cycles(3);
        check("rst_addr_ok2", 32'(bus2.addr_ok), 32'd0);
        check("rst_data_ok2", 32'(bus2.data_ok), 32'd0);
        check("rst_rdata2", bus2.rdata, 32'h0);
        check("rst_addr_ok7", 32'(bus7.addr_ok), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_addr_ok2", 32'(bus2.addr_ok), 32'd1);
        check("post_rst_addr_ok7", 32'(bus7.addr_ok), 32'd1);

        // Write then read back.
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, e[0]);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, e[1]);
        wait_cycles(10);
        expect_resp(0, "wr_ack", 32'h0, e[0]);
        expect_resp(0, "rd_back", 32'hDEADBEEF, e[1]);
        check("t1_extra", 32'(r2_d.size()), 32'd0);

        // Byte-strobe merge, lane 1 only and lanes 0+3.
        issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, e[0]);
        issue(0, 1'b1, 32'h20, 4'b0010, 32'h0000AA00, e[1]);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0, e[2]);
        wait_cycles(10);
        expect_resp(0, "mrg_pre", 32'h0, e[0]);
        expect_resp(0, "mrg_wr", 32'h0, e[1]);
        expect_resp(0, "mrg_rd", 32'h1122AA44, e[2]);
        issue(0, 1'b1, 32'h24, 4'hF, 32'h0, e[0]);
        issue(0, 1'b1, 32'h24, 4'b1001, 32'hAABBCCDD, e[1]);
        issue(0, 1'b0, 32'h24, 4'h0, 32'h0, e[2]);
        wait_cycles(10);
        expect_resp(0, "mrg2_pre", 32'h0, e[0]);
        expect_resp(0, "mrg2_wr", 32'h0, e[1]);
        expect_resp(0, "mrg2_rd", 32'hAA0000DD, e[2]);

        // Upper address bits alias onto the same word.
        issue(0, 1'b1, 32'h0000_1004, 4'hF, 32'hCAFEF00D, e[0]);
        issue(0, 1'b0, 32'h0000_0004, 4'h0, 32'h0, e[1]);
        issue(0, 1'b0, 32'h0000_1010, 4'h0, 32'h0, e[2]);
        wait_cycles(10);
        expect_resp(0, "wrap_wr", 32'h0, e[0]);
        expect_resp(0, "wrap_rd", 32'hCAFEF00D, e[1]);
        expect_resp(0, "wrap_rd2", 32'hDEADBEEF, e[2]);

        // Back-to-back reads give back-to-back responses.
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0, e[0]);
        issue(0, 1'b0, 32'h24, 4'h0, 32'h0, e[1]);
        issue(0, 1'b0, 32'h04, 4'h0, 32'h0, e[2]);
`ifndef SRAM_LIKE_RESP_RANDOM_STALL_EN
        check("b2b_acc", 32'(e[2] - e[0]), 32'd2);
`endif
        wait_cycles(10);
        expect_resp(0, "b2b_0", 32'h1122AA44, e[0]);
        expect_resp(0, "b2b_1", 32'hAA0000DD, e[1]);
        expect_resp(0, "b2b_2", 32'hCAFEF00D, e[2]);
        check("b2b_extra", 32'(r2_d.size()), 32'd0);

        // Queue full on the LAT=7 instance: 5 reads, the 5th waits for the first pop.
        r7_d.delete(); r7_c.delete();
        issue(1, 1'b0, 32'h10, 4'h0, 32'h0, e[0]);
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, e[1]);
        issue(1, 1'b0, 32'h24, 4'h0, 32'h0, e[2]);
        issue(1, 1'b0, 32'h04, 4'h0, 32'h0, e[3]);
        issue(1, 1'b0, 32'h1010, 4'h0, 32'h0, e[4]);
`ifndef SRAM_LIKE_RESP_RANDOM_STALL_EN
        check("full_acc4", 32'(e[3] - e[0]), 32'd3);
        check("full_acc5", 32'(e[4] - e[0]), 32'd8);
`endif
        wait_cycles(20);
        expect_resp(1, "full_0", 32'hDEADBEEF, e[0]);
        expect_resp(1, "full_1", 32'h1122AA44, e[1]);
        expect_resp(1, "full_2", 32'hAA0000DD, e[2]);
        expect_resp(1, "full_3", 32'hCAFEF00D, e[3]);
        expect_resp(1, "full_4", 32'hDEADBEEF, e[4]);
        check("full_extra", 32'(r7_d.size()), 32'd0);

        // Reset with three reads outstanding drops them; memory survives.
        r7_d.delete(); r7_c.delete();
        issue(1, 1'b0, 32'h10, 4'h0, 32'h0, e[0]);
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, e[1]);
        issue(1, 1'b0, 32'h24, 4'h0, 32'h0, e[2]);
        reset = 1'b1;
        #1;
        check("midrst_addr_ok", 32'(bus7.addr_ok), 32'd0);
        check("midrst_data_ok", 32'(bus7.data_ok), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_post_addr_ok", 32'(bus7.addr_ok), 32'd1);
        wait_cycles(12);
        check("midrst_dropped", 32'(r7_d.size()), 32'd0);
        issue(1, 1'b0, 32'h10, 4'h0, 32'h0, eg);
        wait_cycles(10);
        expect_resp(1, "midrst_mem", 32'hDEADBEEF, eg);

        // Random traffic on the LAT=7 instance against a scoreboard.
        wait_cycles(10);
        r7_d.delete(); r7_c.delete();
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            issue(1, 1'b1, 32'h100 + 32'(4 * i), 4'hF, model[i], eg);
            if (eg >= 0) begin exp_d.push_back(32'h0); exp_e.push_back(eg); end
        end
        for (int n = 0; n < 100; n++) begin
            int          wi;
            logic        w;
            logic [3:0]  s;
            logic [31:0] d;
            logic [31:0] a;
            wi = $urandom_range(0, 7);
            w  = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            a  = 32'h100 + 32'(4 * wi) + (($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0);
            issue(1, w, a, s, d, eg);
            if (eg >= 0) begin
                exp_d.push_back(w ? 32'h0 : model[wi]);
                exp_e.push_back(eg);
                if (w) begin
                    for (int b = 0; b < 4; b++) if (s[b]) model[wi][8*b +: 8] = d[8*b +: 8];
                end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_cycles(30);
        check("rnd_count", 32'(r7_d.size()), 32'(exp_d.size()));
        while (exp_d.size() > 0) begin
            expect_resp(1, "rnd", exp_d.pop_front(), exp_e.pop_front());
        end
        check("full_gate2", 32'(viol2), 32'd0);
        check("full_gate7", 32'(viol7), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
